// File: rtl/vp_pkg.sv
// Shared types and widths for the video-process path.
package vp_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned RGB565_W    = 16;
  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned SKIP_CNT_W  = 8;
  localparam int unsigned MEAS_W      = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } cap_state_e;

  // Registered camera bus sample
  typedef struct packed {
    logic              vs;
    logic              href;
    logic [BYTE_W-1:0] data;
  } dvp_in_t;

  // Saturating increment for the line/pixel measurement counters
  function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
    return (v == '1) ? v : v + MEAS_W'(1);
  endfunction

endpackage

// File: rtl/dvp_byte_packer.sv
// Pairs consecutive DVP bytes into one RGB565 word; flags lines that end on an unpaired byte.
module dvp_byte_packer
  import vp_pkg::*;
#(
  parameter int unsigned SWAP_BYTES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                href_r,
  input  logic [BYTE_W-1:0]   data_r,
  output logic                de,
  output logic [RGB565_W-1:0] data,
  output logic                odd_err
);

  logic              phase;
  logic              href_d;
  logic [BYTE_W-1:0] byte_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      href_d  <= 1'b0;
      byte_a  <= '0;
      de      <= 1'b0;
      data    <= '0;
      odd_err <= 1'b0;
    end else if (clear) begin
      phase   <= 1'b0;
      href_d  <= 1'b0;
      de      <= 1'b0;
      odd_err <= 1'b0;
    end else begin
      href_d  <= href_r;
      de      <= 1'b0;
      odd_err <= 1'b0;
      if (href_r) begin
        if (!phase) begin
          byte_a <= data_r;
          phase  <= 1'b1;
        end else begin
          data  <= (SWAP_BYTES != 0) ? {data_r, byte_a} : {byte_a, data_r};
          de    <= 1'b1;
          phase <= 1'b0;
        end
      end else begin
        // Phase is forced to 0 between lines so every line starts on byte A
        phase <= 1'b0;
        if (href_d && phase) odd_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: 8-bit byte bus to RGB565 pixels, with start-up frame skipping.
// Optional line/frame measurement outputs when DVP_CAPTURE_STATS_EN is defined.
module dvp_capture
  import vp_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned VS_POL      = 1,
  parameter int unsigned SWAP_BYTES  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   EN,
  input  logic                   err_clr,
  input  logic                   cam_vs,
  input  logic                   cam_href,
  input  logic [BYTE_W-1:0]      cam_data,
  output logic                   vi_vs,
  output logic                   vi_de,
  output logic [RGB565_W-1:0]    vi_data,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_odd
`ifdef DVP_CAPTURE_STATS_EN
  ,
  output logic [MEAS_W-1:0]      meas_x,
  output logic [MEAS_W-1:0]      meas_y
`endif
);

  dvp_in_t               in_r;
  logic                  vs_d;
  logic                  vs_rise;
  cap_state_e            state, state_nxt;
  logic [SKIP_CNT_W-1:0] skip_cnt, skip_nxt;
  logic                  frame_inc;
  logic                  run_nxt;
  logic                  pk_clear;
  logic                  pk_de;
  logic [RGB565_W-1:0]   pk_data;
  logic                  pk_odd_err;

  // Input stage, vsync normalised to active-high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_r <= '0;
      vs_d <= 1'b0;
    end else begin
      in_r.vs   <= (VS_POL != 0) ? cam_vs : ~cam_vs;
      in_r.href <= cam_href;
      in_r.data <= cam_data;
      vs_d      <= in_r.vs;
    end
  end

  assign vs_rise = in_r.vs & ~vs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    frame_inc = 1'b0;
    if (!EN) begin
      state_nxt = IDLE;
      skip_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SKIP;
          skip_nxt  = '0;
        end
        SKIP: begin
          if (vs_rise) begin
            if (skip_cnt == SKIP_CNT_W'(SKIP_FRAMES)) begin
              state_nxt = RUN;
              frame_inc = 1'b1;
            end else begin
              skip_nxt = skip_cnt + SKIP_CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (vs_rise) frame_inc = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign run_nxt  = (state_nxt == RUN);
  assign pk_clear = (state != RUN) | ~EN;

  dvp_byte_packer #(
    .SWAP_BYTES(SWAP_BYTES)
  ) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (pk_clear),
    .href_r (in_r.href),
    .data_r (in_r.data),
    .de     (pk_de),
    .data   (pk_data),
    .odd_err(pk_odd_err)
  );

  // Output stage; gating on the next state drops everything the cycle after EN falls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vi_vs     <= 1'b0;
      vi_de     <= 1'b0;
      vi_data   <= '0;
      frame_cnt <= '0;
      err_odd   <= 1'b0;
    end else begin
      vi_vs     <= in_r.vs & run_nxt;
      vi_de     <= pk_de & run_nxt;
      if (pk_de && run_nxt) vi_data <= pk_data;
      frame_cnt <= frame_cnt + FRAME_CNT_W'(frame_inc);
      if (pk_odd_err)   err_odd <= 1'b1;
      else if (err_clr) err_odd <= 1'b0;
    end
  end

`ifdef DVP_CAPTURE_STATS_EN
  logic              href_rd;
  logic              href_rise;
  logic              href_fall;
  logic [MEAS_W-1:0] x_cnt;
  logic [MEAS_W-1:0] x_last;
  logic [MEAS_W-1:0] y_cnt;

  assign href_rise = in_r.href & ~href_rd;
  assign href_fall = ~in_r.href & href_rd;

  // The last pixel of a line leaves the packer in the same cycle the line end is seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      href_rd <= 1'b0;
      x_cnt   <= '0;
      x_last  <= '0;
      y_cnt   <= '0;
      meas_x  <= '0;
      meas_y  <= '0;
    end else begin
      href_rd <= in_r.href;
      if (state != RUN) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else begin
        if (href_fall) begin
          x_last <= pk_de ? sat_inc(x_cnt) : x_cnt;
          x_cnt  <= '0;
        end else if (pk_de) begin
          x_cnt <= sat_inc(x_cnt);
        end
        if (vs_rise) begin
          meas_x <= x_last;
          meas_y <= y_cnt;
          y_cnt  <= '0;
        end else if (href_rise) begin
          y_cnt <= sat_inc(y_cnt);
        end
      end
    end
  end
`endif

endmodule
